// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer decremented by prescaled rising edges of tick_in.
// Load/start/stop controls drive a four-state FSM; done/load_err are one-cycle pulses.
module countdown_timer #(
    parameter int unsigned TICKS_PER_SEC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        load,
    input  logic [15:0] ld_value,
    input  logic        start,
    input  logic        stop,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        done,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);

    state_t      state_q, state_d;
    logic [15:0] digits_q, digits_d;
    logic [7:0]  presc_q, presc_d;
    logic        tick_prev_q;
    logic        done_q, done_d;
    logic        load_err_q, load_err_d;

    logic        tick_edge;
    logic        ld_ok;
    logic [15:0] dec_digits;

    assign tick_edge = tick_in & ~tick_prev_q;

    assign ld_ok = (ld_value[15:12] <= 4'd9) && (ld_value[11:8] <= 4'd9) &&
                   (ld_value[7:4]   <= 4'd5) && (ld_value[3:0]  <= 4'd9);

    // One-second BCD decrement with borrow chain s1 -> s10 -> m1 -> m10; 0000 holds.
    always_comb begin
        dec_digits = digits_q;
        if (digits_q[3:0] != 4'd0) begin
            dec_digits[3:0] = digits_q[3:0] - 4'd1;
        end else if (digits_q[7:4] != 4'd0) begin
            dec_digits[7:0] = {digits_q[7:4] - 4'd1, 4'd9};
        end else if (digits_q[11:8] != 4'd0) begin
            dec_digits[11:0] = {digits_q[11:8] - 4'd1, 4'd5, 4'd9};
        end else if (digits_q[15:12] != 4'd0) begin
            dec_digits = {digits_q[15:12] - 4'd1, 4'd9, 4'd5, 4'd9};
        end
    end

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        presc_d    = presc_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (ld_ok) begin
                        digits_d = ld_value;
                        presc_d  = '0;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (start && (digits_q != '0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Load and stop both pre-empt counting for the cycle they occur in.
                if (load) begin
                    load_err_d = 1'b1;
                end else if (stop) begin
                    state_d = PAUSE;
                end else if (tick_edge) begin
                    if (presc_q >= PRESC_MAX) begin
                        presc_d  = '0;
                        digits_d = dec_digits;
                        if (dec_digits == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 8'd1;
                    end
                end
            end
            PAUSE: begin
                if (load) begin
                    if (ld_ok) begin
                        digits_d = ld_value;
                        presc_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end else if (start) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (load) begin
                    if (ld_ok) begin
                        digits_d = ld_value;
                        presc_d  = '0;
                        state_d  = IDLE;
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            digits_q    <= '0;
            presc_q     <= '0;
            tick_prev_q <= 1'b0;
            done_q      <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            presc_q     <= presc_d;
            tick_prev_q <= tick_in;
            done_q      <= done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign digits   = digits_q;
    assign running  = (state_q == RUN);
    assign expired  = (state_q == DONE);
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed steps plus random traffic checked against a
// seconds-based reference model; a second instance covers TICKS_PER_SEC=2.
module tb_countdown_timer;

    logic        clk;
    logic        rst;
    logic        tick_in, load, start, stop;
    logic [15:0] ld_value;
    logic [15:0] digits;
    logic        running, expired, done, load_err;

    logic        t2_tick, t2_load, t2_start, t2_stop;
    logic [15:0] t2_value;
    logic [15:0] d2_digits;
    logic        d2_running, d2_expired, d2_done, d2_load_err;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: time in whole seconds, state 0=idle 1=run 2=pause 3=done.
    int m_secs, m_state, m_pre, m_prev, m_done, m_err;
    int m_tps = 1;

    countdown_timer #(.TICKS_PER_SEC(1)) u_dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .load(load), .ld_value(ld_value),
        .start(start), .stop(stop), .digits(digits), .running(running),
        .expired(expired), .done(done), .load_err(load_err)
    );

    countdown_timer #(.TICKS_PER_SEC(2)) u_dut2 (
        .clk(clk), .rst(rst), .tick_in(t2_tick), .load(t2_load), .ld_value(t2_value),
        .start(t2_start), .stop(t2_stop), .digits(d2_digits), .running(d2_running),
        .expired(d2_expired), .done(d2_done), .load_err(d2_load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] sec2bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int bcd2sec(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v);
        return (v[15:12] <= 9) && (v[11:8] <= 9) && (v[7:4] <= 5) && (v[3:0] <= 9);
    endfunction

    task automatic model_reset();
        m_secs = 0; m_state = 0; m_pre = 0; m_prev = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit ld, input logic [15:0] v, input bit st,
                              input bit sp, input bit tk);
        bit edge_seen;
        edge_seen = tk && (m_prev == 0);
        m_prev = tk ? 1 : 0;
        m_done = 0;
        m_err  = 0;
        if (m_state == 1) begin
            if (ld) m_err = 1;
            else if (sp) m_state = 2;
            else if (edge_seen) begin
                if (m_pre == m_tps - 1) begin
                    m_pre  = 0;
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin
                        m_state = 3;
                        m_done  = 1;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
        end else if (ld) begin
            if (bcd_ok(v)) begin
                m_secs  = bcd2sec(v);
                m_pre   = 0;
                m_state = 0;
            end else begin
                m_err = 1;
            end
        end else if (st && ((m_state == 2) || (m_state == 0 && m_secs != 0))) begin
            m_state = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("digits",   digits,          sec2bcd(m_secs));
        chk("running",  16'(running),    16'(m_state == 1));
        chk("expired",  16'(expired),    16'(m_state == 3));
        chk("done",     16'(done),       16'(m_done));
        chk("load_err", 16'(load_err),   16'(m_err));
    endtask

    task automatic cycle(input bit ld, input logic [15:0] v, input bit st,
                         input bit sp, input bit tk);
        load = ld; ld_value = v; start = st; stop = sp; tick_in = tk;
        model_step(ld, v, st, sp, tk);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cycle2(input bit ld, input logic [15:0] v, input bit st,
                          input bit sp, input bit tk);
        t2_load = ld; t2_value = v; t2_start = st; t2_stop = sp; t2_tick = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, '0, 0, 0, 1);
            for (int j = 0; j < 4; j++) cycle(0, '0, 0, 0, 0);
        end
    endtask

    initial begin
        bit          r_ld, r_st, r_sp, r_tk;
        int          r;
        logic [15:0] r_v;

        rst = 1'b1;
        {tick_in, load, start, stop} = '0;
        ld_value = '0;
        {t2_tick, t2_load, t2_start, t2_stop} = '0;
        t2_value = '0;
        model_reset();
        #12;
        check_all();
        chk("rst_d2_digits", d2_digits, 16'h0000);
        rst = 1'b0;

        cycle(1, 16'h0003, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        chk("run_after_start", 16'(running), 16'd1);
        cycle(0, '0, 0, 0, 1);
        chk("first_dec", digits, 16'h0002);
        for (int j = 0; j < 4; j++) cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 0, 1);
        chk("second_dec", digits, 16'h0001);
        for (int j = 0; j < 4; j++) cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 0, 1);
        chk("zero_digits", digits, 16'h0000);
        chk("zero_done", 16'(done), 16'd1);
        chk("zero_expired", 16'(expired), 16'd1);
        cycle(0, '0, 0, 0, 1);
        chk("done_one_cycle", 16'(done), 16'd0);
        cycle(0, '0, 1, 0, 0);

        cycle(1, 16'h1000, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 1);
        chk("min_borrow", digits, 16'h0959);
        cycle(0, '0, 0, 1, 0);
        cycle(1, 16'h0100, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 1);
        chk("sec_borrow", digits, 16'h0059);
        cycle(0, '0, 0, 1, 0);

        cycle(1, 16'h9A00, 0, 0, 0);
        chk("bad_m1_err", 16'(load_err), 16'd1);
        chk("bad_m1_keep", digits, 16'h0059);
        cycle(1, 16'h0060, 0, 0, 0);
        chk("bad_s10_err", 16'(load_err), 16'd1);
        cycle(1, 16'h0000, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        chk("start_at_zero", 16'(running), 16'd0);

        cycle(1, 16'h0030, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 1, 1);
        chk("stop_vs_edge", digits, 16'h0030);
        chk("stop_pauses", 16'(running), 16'd0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 1);
        chk("resume_dec", digits, 16'h0029);
        cycle(1, 16'h0010, 0, 0, 1);
        chk("load_in_run_err", 16'(load_err), 16'd1);
        chk("load_in_run_keep", digits, 16'h0029);

        cycle2(1, 16'h0005, 0, 0, 0);
        cycle2(0, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle2(0, '0, 0, 0, 1);
            cycle2(0, '0, 0, 0, 0);
        end
        chk("tps2_three_edges", d2_digits, 16'h0004);
        cycle2(0, '0, 0, 1, 0);
        chk("tps2_paused", 16'(d2_running), 16'd0);
        cycle2(0, '0, 1, 0, 0);
        cycle2(0, '0, 0, 0, 1);
        chk("tps2_presc_kept", d2_digits, 16'h0003);
        cycle2(0, '0, 0, 0, 0);

        cycle(1, 16'h0042, 0, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("async_rst_d2", d2_digits, 16'h0000);
        rst = 1'b0;
        model_step(0, '0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_all();
        cycle(0, '0, 1, 0, 0);
        chk("start_after_rst", 16'(running), 16'd0);

        for (int i = 0; i < 600; i++) begin
            r    = int'($urandom_range(0, 99));
            r_ld = (r < 8);
            r_st = (r >= 8 && r < 20);
            r_sp = (r >= 20 && r < 24);
            r_tk = ($urandom_range(0, 1) == 1);
            if (r_ld) r_tk = (m_prev != 0);
            if ($urandom_range(0, 3) == 0) r_v = 16'($urandom);
            else if ($urandom_range(0, 7) == 0) r_v = sec2bcd(int'($urandom_range(0, 5999)));
            else r_v = sec2bcd(int'($urandom_range(0, 20)));
            cycle(r_ld, r_v, r_st, r_sp, r_tk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

BCD mm:ss countdown timer driven by the slow tick produced by the clock divider. Rising edges of the divider output are detected in the `clk` domain and, after an optional prescale, each decrements the displayed time by one second while running. Start/stop/load controls come from debounced button logic. Digit outputs feed the seven-segment display driver, and `expired`/`done` drive the alarm logic.

## Interface
- `TICKS_PER_SEC`, default 1: rising edges of `tick_in` per one-second decrement; legal range 1..255.
- `clk` in 1: system clock; every register is clocked on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `tick_in` in 1: clock-divider output level, synchronous to `clk`.
- `load` in 1: one-cycle load request.
- `ld_value` in 16: BCD {m10,m1,s10,s1}, sampled when `load`=1.
- `start` in 1: one-cycle start request.
- `stop` in 1: one-cycle stop (pause) request.
- `digits` out 16: current BCD {m10,m1,s10,s1}.
- `running` out 1: level, state==RUN.
- `expired` out 1: level, state==DONE.
- `done` out 1: one-cycle pulse when the count reaches 0000.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation
- **Edge detect**
  - `tick_prev` register; `edge` = `tick_in` & ~`tick_prev`.
  - `tick_prev` resets to 0.
- **Prescale counter**
  - Width 8. Counts `edge` only in RUN.
  - When it reaches TICKS_PER_SEC-1 and `edge`=1, it wraps to 0 and issues one decrement.
  - Cleared on reset and on an accepted load. Held, not cleared, in PAUSE.
- **FSM states:** IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- **Load validity:** a value is valid iff m10, m1 and s1 are each ≤9 and s10 ≤5.
- **Per-cycle priority:** load, then stop, then start, then decrement.
- **IDLE**
  - Valid load: `digits`←`ld_value`, stay IDLE.
  - Invalid load: `load_err`, no other change.
  - `start` with `digits`≠0000 and no load: go to RUN.
  - `start` with `digits`=0000: ignored.
- **RUN**
  - `load`: ignored, `load_err` pulses.
  - `stop`: go to PAUSE; any decrement in the same cycle is discarded. `stop`+`start` together: stop wins.
  - Decrement rule:
    - s1>0: s1−1.
    - Else s1=9 and s10 borrows: s10>0 gives s10−1; else s10=5 and the borrow moves into minutes.
    - Minutes follow the same scheme with m1 wrapping 0→9 and m10 borrowing.
  - A decrement producing 0000 enters DONE.
- **PAUSE**
  - `start`: go to RUN, keeping the prescale count.
  - Valid load: load `digits`, go to IDLE.
  - Invalid load: `load_err` pulses, stay PAUSE.
  - `stop`: no effect.
- **DONE**
  - `digits`=0000 and `expired`=1.
  - `start` and `stop` are ignored.
  - Valid load: go to IDLE. Invalid load: `load_err` pulses, stay DONE.
- `digits` never leaves the valid BCD range; 0000 is never decremented.

## Timing
- **Reset values:** `digits`=0000, `running`=0, `expired`=0, `done`=0, `load_err`=0, prescaler=0, `tick_prev`=0.
- **Counting latency:** `tick_in` rising in cycle N (seen as `edge`) updates `digits` at the clock edge ending cycle N, so the new value is visible in cycle N+1.
- **Expiry:** `done` and `expired` rise in the same cycle that `digits` first shows 0000. `done` is high for exactly one cycle.
- **Control latency:** `load`, `start` and `stop` sampled in cycle N take effect in cycle N+1. `running` changes in N+1.
- **`load_err`:** high in cycle N+1 for a rejected load in cycle N.
- **Level input:** a `tick_in` held high produces exactly one `edge`.
- **Reset mid-operation:** `rst` asserted in any state forces all reset values immediately, without waiting for a `clk` edge.

## Test plan
- Reset, then load 0003, start, drive `tick_in` as 1-cycle-high / 4-cycle-low → `digits` 0002, 0001, 0000. `done` pulses once with 0000, `expired`=1, `running`=0.
- Load 1000, start, one edge → `digits`=0959. Load 0100, start, one edge → `digits`=0059.
- Load 9A00 → `load_err` pulse, `digits` unchanged. Load 0060 → `load_err` pulse. Load 0000 then start → state stays IDLE, `running`=0.
- RUN at 0030, assert `stop` in the same cycle as an edge → `digits` stays 0030, state PAUSE. `start` → RUN, next edge gives 0029. `load` in RUN → `load_err` pulse, value unchanged.
- TICKS_PER_SEC=2: load 0005, start, 3 edges → 0004. Stop, start, 1 edge → 0003 (prescale count retained across the pause).
- Assert `rst` asynchronously mid-RUN at 0042 → all outputs go to reset values before the next `clk` edge. A later `start` is ignored because `digits`=0000.
